// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register bank: NUM_REGS 32-bit registers decoded at BASE_ADDR,
// with read-only entries mirrored from reg_in and per-register write strobes.
module axil_slave_regfile #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        NUM_REGS       = 16,
    parameter logic [NUM_REGS-1:0]       RO_MASK        = '0
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [AXI_ADDR_WIDTH-1:0]            s_axil_awaddr,
    input  logic                                 s_axil_awvalid,
    output logic                                 s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]            s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]          s_axil_wstrb,
    input  logic                                 s_axil_wvalid,
    output logic                                 s_axil_wready,
    output logic [1:0]                           s_axil_bresp,
    output logic                                 s_axil_bvalid,
    input  logic                                 s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]            s_axil_araddr,
    input  logic                                 s_axil_arvalid,
    output logic                                 s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]            s_axil_rdata,
    output logic [1:0]                           s_axil_rresp,
    output logic                                 s_axil_rvalid,
    input  logic                                 s_axil_rready,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_out,
    input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_in,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    // Returns {miss, index}; miss covers both below-window and past-the-end addresses.
    function automatic logic [IDX_W:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        logic [AXI_ADDR_WIDTH-1:0] word;
        logic                      miss;
        offset = addr - BASE_ADDR;
        word   = offset >> 2;
        miss   = (addr < BASE_ADDR) || (word >= AXI_ADDR_WIDTH'(NUM_REGS));
        return {miss, word[IDX_W-1:0]};
    endfunction

    function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]         strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                      live;
    logic                      aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]       pulse_q;
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] view   [NUM_REGS];

    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]         wr_strb;
    logic [IDX_W:0]            wr_dec, rd_dec;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic [1:0]                wr_resp, rd_resp;
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic                      commit, aw_fire, w_fire, ar_fire;

    // RO entries track reg_in live; RW entries come from storage.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            view[i] = RO_MASK[i] ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : regs_q[i];
            reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = view[i];
        end
    end

    // A held beat takes priority; otherwise the beat on the bus this cycle is used.
    assign wr_addr = aw_held ? aw_addr_q : s_axil_awaddr;
    assign wr_data = w_held  ? w_data_q  : s_axil_wdata;
    assign wr_strb = w_held  ? w_strb_q  : s_axil_wstrb;
    assign wr_dec  = decode(wr_addr);
    assign wr_idx  = wr_dec[IDX_W-1:0];
    assign wr_resp = wr_dec[IDX_W]   ? RESP_DECERR :
                     RO_MASK[wr_idx] ? RESP_SLVERR : RESP_OKAY;

    assign rd_dec  = decode(s_axil_araddr);
    assign rd_idx  = rd_dec[IDX_W-1:0];
    assign rd_resp = rd_dec[IDX_W] ? RESP_DECERR : RESP_OKAY;
    assign rd_data = rd_dec[IDX_W] ? '0 : view[rd_idx];

    assign commit  = (w_state == W_IDLE) && live &&
                     (aw_held || s_axil_awvalid) && (w_held || s_axil_wvalid);
    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid  && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;

    always_comb begin
        w_next         = w_state;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axil_awready = live && !aw_held;
                s_axil_wready  = live && !w_held;
                if (commit) w_next = W_RESP;
            end
            W_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next         = r_state;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axil_arready = live;
                if (ar_fire) r_next = R_RESP;
            end
            R_RESP: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            live    <= 1'b1;
        end
    end

    // Write path: capture AW/W independently, commit once both are present.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pulse_q <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_resp;
                if (wr_resp == RESP_OKAY) begin
                    regs_q[wr_idx]  <= merge_bytes(regs_q[wr_idx], wr_data, wr_strb);
                    pulse_q[wr_idx] <= 1'b1;
                end
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axil_wdata;
                    w_strb_q <= s_axil_wstrb;
                end
            end
        end
    end

    // Read path: sample on AR handshake so a same-edge write is not visible.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
        end
    end

    assign s_axil_bresp = bresp_q;
    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = rresp_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: doc/axil_slave_regfile.md
Name: axil_slave_regfile

Overview:
- AXI-Lite slave endpoint. It is the responder that sits on one slave port of the priority interconnect.
- Decodes a window at BASE_ADDR of size NUM_REGS words into a bank of 32-bit control/status registers.
- Exposes register contents to user logic, and takes status inputs for read-only registers.
- Returns OKAY, SLVERR or DECERR per AXI-Lite rules.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- AXI_ADDR_WIDTH, 32, address bus width.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; matches this port's interconnect offset.
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
- RO_MASK, 16'h0000 (NUM_REGS bits), bit i=1 makes register i read-only (sourced from reg_in).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  AXI_DATA_WIDTH  write data
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  AXI_DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents, reg i at [32i+31:32i]
- reg_in  in  NUM_REGS*AXI_DATA_WIDTH  status values for RO registers
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe per register on successful write

Behaviour:
- One clock, aclk. areset is asynchronous and active-high.
- While areset is high, all registers = 0, and all ready, valid and resp outputs, rdata and reg_wr_pulse = 0. Ready outputs rise in the first cycle after deassertion.
- Reset mid-transaction: abort the transaction, drop bvalid/rvalid immediately, and lose captured AW/W/AR.
- Decode, word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored:
  - address below BASE_ADDR or index >= NUM_REGS -> DECERR (2'b11), no register change;
  - write to an RO register -> SLVERR (2'b10), no register change;
  - otherwise -> OKAY (2'b00).
- Write FSM W_IDLE -> W_RESP:
  - awready = 1 until AW is captured; wready = 1 until W is captured. AW and W are captured independently, in either order or the same cycle.
  - On the edge where both are held, the write commits: bytes with wstrb=1 are updated, wstrb=0 bytes are kept. The FSM enters W_RESP.
  - In W_RESP: bvalid=1, bresp held stable, awready=wready=0.
  - reg_wr_pulse[i]=1 for the first W_RESP cycle only, on OKAY only. It fires even if wstrb=0.
  - bvalid & bready -> W_IDLE; ready outputs return high the next cycle.
  - Latency: last of AW/W handshake at cycle N -> bvalid and new reg_out at N+1.
- Read FSM R_IDLE -> R_RESP:
  - arready = 1 in R_IDLE. On the AR handshake, rdata and rresp are registered and the FSM enters R_RESP.
  - rdata source: RO register -> reg_in slice; RW register -> current value; DECERR -> 0.
  - rvalid is held with stable data until rready; then return to R_IDLE.
  - Latency: AR handshake at cycle N -> rvalid at N+1.
- Read and write FSMs are independent and may run concurrently.
- Read and write to the same register committing on the same edge: the read returns the old value.
- reg_out for RO indices mirrors reg_in combinationally. RW registers are not affected by reg_in.
- Back-to-back throughput: one write per 2 cycles, one read per 2 cycles. No outstanding transactions beyond one per channel.

Test Plan:
- Reset, then write 0xDEADBEEF, wstrb=4'hF to BASE+0x8; AW and W in the same cycle -> bvalid next cycle, bresp=00, reg_out[2]=0xDEADBEEF, reg_wr_pulse=0x0004 for one cycle. Read BASE+0x8 -> rdata=0xDEADBEEF, rresp=00.
- W arrives 3 cycles before AW, wdata=0x12345678, wstrb=4'b0101, target reg 3 preloaded 0xFFFFFFFF -> reg_out[3]=0xFF34FF78, single bvalid.
- RO_MASK=16'h0010, reg_in[4]=0xCAFE0001. Write reg 4 -> bresp=10, no pulse. Read reg 4 -> 0xCAFE0001, rresp=00.
- Write BASE+0x40 with NUM_REGS=16 -> bresp=11. Read BASE+0x40 -> rdata=0, rresp=11.
- bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout. Same for rready and rvalid with stable rdata.
- Read and write of reg 1 (old 0x1, new 0x2) handshake on the same edge -> rdata=0x1, reg_out[1]=0x2. Assert areset while bvalid=1 -> bvalid=0 immediately, all regs=0.
